fft_out_collector: RTL and testbench

Downstream stage of the DIT FFT core. Captures every result word the core emits on its push/data output, splits it into signed real/imaginary parts, tags it with its bin index and frame markers, and buffers it in a small FIFO. Results are presented to the consumer over a valid/ready handshake. The FFT core has no backpressure, so any result arriving while the buffer is full is dropped and flagged.

---
 rtl/fft_out_pkg.sv | 17 +
 rtl/fft_out_fifo.sv | 37 +++
 rtl/fft_out_collector.sv | 116 +++++++++++
 tb/tb_fft_out_collector.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_out_pkg.sv
// fft_out_pkg: shared widths and the buffered FFT result entry type
// Optional feature macro FFT_OUT_MAG_EN adds a 48-bit magnitude field to fft_bin_t.
package fft_out_pkg;
  localparam int DW = 24;
  localparam int WW = 48;
  localparam int IW_MAX = 16;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [IW_MAX-1:0] idx;
    logic first;
    logic last;
`ifdef FFT_OUT_MAG_EN
    logic [WW-1:0] mag;
`endif
  } fft_bin_t;
endpackage

// File: rtl/fft_out_fifo.sv
// fft_out_fifo: synchronous FIFO of fft_bin_t entries with simultaneous push/pop
// Ports: clk, reset (sync, active-high), i_push/i_data write, i_pop read,
//        o_data = head entry (valid when !o_empty), o_full, o_empty.
module fft_out_fifo
  import fft_out_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  fft_bin_t i_data,
  input  logic     i_pop,
  output fft_bin_t o_data,
  output logic     o_full,
  output logic     o_empty
);
  localparam int AW = $clog2(DEPTH);
  fft_bin_t r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  always_ff @(posedge clk) if (i_push) r_mem[r_wp] <= i_data;
  assign o_data = r_mem[r_rp];
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
endmodule

// File: rtl/fft_out_collector.sv
// fft_out_collector: tags FFT results with bin index/frame markers and buffers them for a valid/ready consumer
// Ports: clk, reset (sync, active-high); fft_push/fft_data from the FFT core (no backpressure);
//        out_valid/out_ready handshake carrying out_re, out_im, out_idx, out_first, out_last;
//        overflow is sticky once a result is dropped. Macro FFT_OUT_MAG_EN adds out_mag = re^2+im^2
//        through a two-stage pipeline ahead of the buffer.
module fft_out_collector
  import fft_out_pkg::*;
#(
  parameter int N_POINTS = 128,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fft_push,
  input  logic [WW-1:0]               fft_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW-1:0]               out_re,
  output logic [DW-1:0]               out_im,
  output logic [$clog2(N_POINTS)-1:0] out_idx,
  output logic                        out_first,
  output logic                        out_last,
  output logic                        overflow
`ifdef FFT_OUT_MAG_EN
  ,
  output logic [WW-1:0]               out_mag
`endif
);
  localparam int IW = $clog2(N_POINTS);
  logic [IW-1:0] r_wr_idx;
  fft_bin_t w_in, w_bin, w_head, r_out;
  logic w_push, w_full, w_empty, w_take, w_fifo_push, w_fifo_pop, w_drop;
  logic r_valid, r_ovf;
  always_comb begin
    w_in = '0;
    w_in.re = fft_data[WW-1:DW];
    w_in.im = fft_data[DW-1:0];
    w_in.idx = IW_MAX'(r_wr_idx);
    w_in.first = r_wr_idx == '0;
    w_in.last = r_wr_idx == IW'(N_POINTS - 1);
  end
  // Counts every push, stored or dropped, so indices stay frame-aligned.
  always_ff @(posedge clk) begin
    if (reset) r_wr_idx <= '0;
    else if (fft_push) r_wr_idx <= r_wr_idx + 1'b1;
  end
`ifdef FFT_OUT_MAG_EN
  fft_bin_t r_s1, r_s2, w_s1m;
  logic r_s1_v, r_s2_v;
  logic [WW-1:0] r_re2, r_im2;
  logic signed [WW-1:0] w_re_x, w_im_x;
  assign w_re_x = {{DW{w_in.re[DW-1]}}, w_in.re};
  assign w_im_x = {{DW{w_in.im[DW-1]}}, w_in.im};
  always_comb begin
    w_s1m = r_s1;
    w_s1m.mag = r_re2 + r_im2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      r_s1_v <= fft_push;
      r_s2_v <= r_s1_v;
    end
  end
  always_ff @(posedge clk) begin
    r_s1 <= w_in;
    r_re2 <= w_re_x * w_re_x;
    r_im2 <= w_im_x * w_im_x;
    r_s2 <= w_s1m;
  end
  assign w_push = r_s2_v;
  assign w_bin = r_s2;
  assign out_mag = r_out.mag;
`else
  assign w_push = fft_push;
  assign w_bin = w_in;
`endif
  // The output register frees up this edge when empty or being transferred;
  // it refills from the FIFO head, or straight from the write side when the FIFO is empty.
  assign w_take = !r_valid || out_ready;
  assign w_fifo_pop = w_take && !w_empty;
  assign w_fifo_push = w_push && !(w_take && w_empty) && (!w_full || w_fifo_pop);
  assign w_drop = w_push && w_full && !w_fifo_pop;
  fft_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_fifo_push),
    .i_data (w_bin),
    .i_pop  (w_fifo_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_out <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_take) begin
        r_valid <= !w_empty || w_push;
        r_out <= !w_empty ? w_head : w_push ? w_bin : r_out;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end
  assign out_valid = r_valid;
  assign out_re = r_out.re;
  assign out_im = r_out.im;
  assign out_idx = IW'(r_out.idx);
  assign out_first = r_out.first;
  assign out_last = r_out.last;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_fft_out_collector.sv
// tb_fft_out_collector: scoreboard bench for fft_out_collector (N_POINTS=128, DEPTH=16)
module tb_fft_out_collector;
  localparam int N = 128;
  localparam int DEPTH = 16;
  localparam int IW = $clog2(N);
  logic clk = 1'b0;
  logic reset, fft_push, out_ready, out_valid, out_first, out_last, overflow;
  logic [47:0] fft_data;
  logic [23:0] out_re, out_im;
  logic [IW-1:0] out_idx;
`ifdef FFT_OUT_MAG_EN
  logic [47:0] out_mag;
`endif
  typedef struct {
    logic [23:0] re;
    logic [23:0] im;
    int idx;
    logic first;
    logic last;
    logic [47:0] mag;
  } exp_t;
  exp_t q[$];
  exp_t pipe[2];
  bit pv[2];
  int m_idx, checks, failures, n_pop, last_idx, n_first;
  bit m_ovf;
  fft_out_collector #(.N_POINTS(N), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .fft_push (fft_push),
    .fft_data (fft_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_idx  (out_idx),
    .out_first(out_first),
    .out_last (out_last),
    .overflow (overflow)
`ifdef FFT_OUT_MAG_EN
    ,
    .out_mag  (out_mag)
`endif
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic [47:0] d, input int idx);
    exp_t e;
    longint r, i;
    r = $signed(d[47:24]);
    i = $signed(d[23:0]);
    e.re = d[47:24];
    e.im = d[23:0];
    e.idx = idx;
    e.first = idx == 0;
    e.last = idx == N - 1;
    e.mag = 48'(r * r + i * i);
    return e;
  endfunction
  task automatic step(input bit p, input logic [47:0] d, input bit rdy);
    exp_t e, arr;
    bit av;
    checks++;
    if (out_valid !== (q.size() > 0)) begin
      failures++;
      $display("FAIL valid got=%0b exp=%0b", out_valid, q.size() > 0);
    end
    checks++;
    if (overflow !== m_ovf) begin
      failures++;
      $display("FAIL overflow got=%0b exp=%0b", overflow, m_ovf);
    end
    if (q.size() > 0 && rdy) begin
      e = q.pop_front();
      n_pop++;
      last_idx = out_idx;
      if (out_first === 1'b1) n_first++;
      checks++;
      if ({out_re, out_im, out_idx, out_first, out_last} !== {e.re, e.im, IW'(e.idx), e.first, e.last}) begin
        failures++;
        $display("FAIL word got re=%0d im=%0d idx=%0d f=%0b l=%0b exp re=%0d im=%0d idx=%0d f=%0b l=%0b",
                 $signed(out_re), $signed(out_im), out_idx, out_first, out_last,
                 $signed(e.re), $signed(e.im), e.idx, e.first, e.last);
      end
`ifdef FFT_OUT_MAG_EN
      checks++;
      if (out_mag !== e.mag) begin
        failures++;
        $display("FAIL mag got=%0d exp=%0d", out_mag, e.mag);
      end
`endif
    end
    fft_push = p;
    fft_data = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
    arr = p ? mk(d, m_idx) : '{default: '0};
    if (p) m_idx = (m_idx + 1) % N;
`ifdef FFT_OUT_MAG_EN
    av = pv[1];
    e = pipe[1];
    pipe[1] = pipe[0];
    pv[1] = pv[0];
    pipe[0] = arr;
    pv[0] = p;
    arr = e;
`else
    av = p;
`endif
    if (av) begin
      if (q.size() < DEPTH + 1) q.push_back(arr);
      else m_ovf = 1'b1;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    fft_push = 1'b0;
    fft_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    pv = '{0, 0};
    m_idx = 0;
    m_ovf = 1'b0;
    n_pop = 0;
    n_first = 0;
    last_idx = -1;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (q.size() > 0 || pv[0] || pv[1]); i++) step(0, '0, 1);
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain left=%0d out_valid=%0b", q.size(), out_valid);
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, out_re, out_im, out_idx, out_first, out_last, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b re=%0d im=%0d idx=%0d f=%0b l=%0b ovf=%0b exp all zero",
               out_valid, out_re, out_im, out_idx, out_first, out_last, overflow);
    end
`ifdef FFT_OUT_MAG_EN
    checks++;
    if (out_mag !== '0) begin
      failures++;
      $display("FAIL reset_mag got=%0d exp=0", out_mag);
    end
`endif
  endtask
  task automatic test_stream();
    do_reset();
    for (int k = 0; k < N; k++) begin
      step(1, {24'(k), 24'(-k)}, 1);
`ifndef FFT_OUT_MAG_EN
      if (k == 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== '0 || out_first !== 1'b1) begin
          failures++;
          $display("FAIL latency got v=%0b idx=%0d f=%0b exp v=1 idx=0 f=1", out_valid, out_idx, out_first);
        end
      end
`endif
    end
    drain();
    checks++;
    if (n_pop != N || last_idx != N - 1 || n_first != 1) begin
      failures++;
      $display("FAIL stream_count got pops=%0d last=%0d firsts=%0d exp %0d %0d 1", n_pop, last_idx, n_first, N, N - 1);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) step(1, {24'(i + 100), 24'(i + 200)}, 0);
    repeat (2) step(0, '0, 0);
    checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b1 || out_re !== 24'd100 || out_im !== 24'd200 || out_idx !== '0) begin
      failures++;
      $display("FAIL hold_full got ovf=%0b v=%0b re=%0d im=%0d idx=%0d exp 0 1 100 200 0",
               overflow, out_valid, out_re, out_im, out_idx);
    end
    step(1, {24'd999, 24'd999}, 0);
    repeat (3) step(0, '0, 0);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set got=%0b exp=1", overflow);
    end
    drain();
    checks++;
    if (n_pop != DEPTH + 1 || last_idx != DEPTH) begin
      failures++;
      $display("FAIL drain_full got pops=%0d last=%0d exp %0d %0d", n_pop, last_idx, DEPTH + 1, DEPTH);
    end
    step(1, {24'd5, 24'd6}, 1);
    drain();
    checks++;
    if (last_idx != DEPTH + 2 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL after_drop got idx=%0d ovf=%0b exp %0d 1", last_idx, overflow, DEPTH + 2);
    end
  endtask
  task automatic test_full_pushpop();
    int cnt;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) step(1, {24'(i), 24'(i)}, 0);
    repeat (2) step(0, '0, 0);
    step(1, {24'd77, 24'd88}, 1);
    repeat (2) step(0, '0, 0);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_ovf got=%0b exp=0", overflow);
    end
    cnt = 0;
    for (int i = 0; i < 40 && out_valid === 1'b1; i++) begin
      cnt++;
      step(0, '0, 1);
    end
    checks++;
    if (cnt != DEPTH + 1 || last_idx != DEPTH + 1) begin
      failures++;
      $display("FAIL pushpop_occupancy got=%0d last=%0d exp %0d %0d", cnt, last_idx, DEPTH + 1, DEPTH + 1);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 60; i++) step(1, {24'(i), 24'(i)}, 1);
    do_reset();
    checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got ovf=%0b v=%0b exp 0 0", overflow, out_valid);
    end
    for (int i = 0; i < 3; i++) step(1, {24'(i + 7), 24'(-(i + 7))}, 1);
    drain();
    checks++;
    if (n_pop != 3 || last_idx != 2 || n_first != 1) begin
      failures++;
      $display("FAIL reset_mid_idx got pops=%0d last=%0d firsts=%0d exp 3 2 1", n_pop, last_idx, n_first);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < N + 2; k++) step(1, {24'(k * 3), 24'(k)}, 1);
    drain();
    checks++;
    if (n_pop != N + 2 || last_idx != 1 || n_first != 2) begin
      failures++;
      $display("FAIL wrap got pops=%0d last=%0d firsts=%0d exp %0d 1 2", n_pop, last_idx, n_first, N + 2);
    end
  endtask
`ifdef FFT_OUT_MAG_EN
  task automatic test_mag();
    do_reset();
    step(1, {24'h800000, 24'h800000}, 1);
    step(1, {24'd3, -24'sd4}, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mag_latency early got v=%0b exp 0", out_valid);
    end
    step(0, '0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_mag !== 48'h8000_0000_0000) begin
      failures++;
      $display("FAIL mag_max got v=%0b mag=%0d exp 1 %0d", out_valid, out_mag, 48'h8000_0000_0000);
    end
    step(0, '0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_mag !== 48'd25) begin
      failures++;
      $display("FAIL mag_small got v=%0b mag=%0d exp 1 25", out_valid, out_mag);
    end
    drain();
  endtask
`endif
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    test_wrap();
`ifdef FFT_OUT_MAG_EN
    test_mag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
